// File: rtl/pad_ctrl_pkg.sv
// Shared types for the pad controller.
//   lane_state_e : per-lane direction FSM states
//   lane_cfg_t   : per-lane request from the register file / pad mux
//   lane_pad_t   : per-lane drive pins towards the pad frame
package pad_ctrl_pkg;

    typedef enum logic [1:0] {
        StIn      = 2'd0,
        StTurnOut = 2'd1,
        StOut     = 2'd2,
        StTurnIn  = 2'd3
    } lane_state_e;

    typedef struct packed {
        logic dir_req;
        logic out_val;
        logic pull_en;
        logic pull_dn;
    } lane_cfg_t;

    typedef struct packed {
        logic oen;
        logic i;
        logic pen;
        logic puen;
    } lane_pad_t;

    // Driver off, data low, pull-up enabled (pen is active-low).
    localparam lane_pad_t PadReset = '{oen: 1'b1, i: 1'b0, pen: 1'b0, puen: 1'b0};

    // Width of a down-counter that must hold values up to n-1 (at least 1 bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/pad_ctrl_lane.sv
// One pad lane: direction FSM with break-before-make turnaround, 2-flop
// receive synchroniser, glitch filter and edge detection.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   cfg_i         : direction / output value / pull request
//   pad_ctl_o     : registered OEN/I/PEN/PUEN towards the pad
//   pad_in_i      : raw, asynchronous pad receiver output
//   rx_val_o      : filtered received level
//   rise_o/fall_o : one-cycle filtered edge events, only while in StIn
//   busy_o        : lane is turning around
module pad_ctrl_lane
    import pad_ctrl_pkg::*;
#(
    parameter int unsigned DeadCycles   = 2,
    parameter int unsigned FilterCycles = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  lane_cfg_t cfg_i,
    output lane_pad_t pad_ctl_o,
    input  logic      pad_in_i,
    output logic      rx_val_o,
    output logic      rise_o,
    output logic      fall_o,
    output logic      busy_o
);

    localparam int unsigned DeadW = cnt_width(DeadCycles);
    localparam int unsigned FiltW = $clog2(FilterCycles + 1);
    localparam logic [DeadW-1:0] DeadLoad = DeadW'(DeadCycles - 1);
    localparam logic [FiltW-1:0] FiltThr  = FiltW'((FilterCycles >= 2) ? FilterCycles - 2 : 0);
    localparam bit SingleSample = (FilterCycles == 1);

    // ---------------- direction FSM ----------------
    lane_state_e      state_q, state_d;
    logic [DeadW-1:0] dead_q, dead_d;
    lane_pad_t        pad_q, pad_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        dead_d  = dead_q;
        pad_d   = pad_q;
        busy_d  = busy_q;
        unique case (state_q)
            StIn: begin
                pad_d.oen = 1'b1;
                if (cfg_i.dir_req) begin
                    // Pull released on the same edge the data is staged.
                    state_d   = StTurnOut;
                    dead_d    = DeadLoad;
                    busy_d    = 1'b1;
                    pad_d.pen = 1'b1;
                    pad_d.i   = cfg_i.out_val;
                end else begin
                    busy_d     = 1'b0;
                    pad_d.pen  = ~cfg_i.pull_en;
                    pad_d.puen = cfg_i.pull_dn;
                end
            end
            StTurnOut: begin
                pad_d.i = cfg_i.out_val;
                if (dead_q == '0) begin
                    state_d   = StOut;
                    busy_d    = 1'b0;
                    pad_d.oen = 1'b0;
                end else begin
                    dead_d = dead_q - 1'b1;
                end
            end
            StOut: begin
                pad_d.i = cfg_i.out_val;
                if (!cfg_i.dir_req) begin
                    // Driver off first; pull stays off until the dead time expires.
                    state_d   = StTurnIn;
                    dead_d    = DeadLoad;
                    busy_d    = 1'b1;
                    pad_d.oen = 1'b1;
                end
            end
            StTurnIn: begin
                if (dead_q == '0) begin
                    state_d    = StIn;
                    busy_d     = 1'b0;
                    pad_d.pen  = ~cfg_i.pull_en;
                    pad_d.puen = cfg_i.pull_dn;
                end else begin
                    dead_d = dead_q - 1'b1;
                end
            end
            default: begin
                state_d = StIn;
                pad_d   = PadReset;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIn;
            dead_q  <= '0;
            pad_q   <= PadReset;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dead_q  <= dead_d;
            pad_q   <= pad_d;
            busy_q  <= busy_d;
        end
    end

    // ---------------- receive path ----------------
    logic [1:0]       sync_q;
    logic [FiltW-1:0] filt_q, filt_d;
    logic             rx_q, rx_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             toggle;

    // filt_q counts consecutive stage-2 samples that differ from rx_q. The
    // stage-1 sample is counted as the newest one, so the level changes on
    // the edge FilterCycles+1 after the pad first presents a new stable value.
    always_comb begin
        toggle = (sync_q[0] != rx_q) &&
                 (SingleSample || ((sync_q[1] != rx_q) && (filt_q >= FiltThr)));
        if (toggle) begin
            filt_d = '0;
        end else if (sync_q[1] != rx_q) begin
            filt_d = filt_q + 1'b1;
        end else begin
            filt_d = '0;
        end
        rx_d   = rx_q ^ toggle;
        rise_d = toggle && (state_q == StIn) && !rx_q;
        fall_d = toggle && (state_q == StIn) && rx_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
            filt_q <= '0;
            rx_q   <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pad_in_i};
            filt_q <= filt_d;
            rx_q   <= rx_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign pad_ctl_o = pad_q;
    assign busy_o    = busy_q;
    assign rx_val_o  = rx_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;

endmodule

// File: rtl/pad_ctrl.sv
// Bank of NumPads independent pad lanes between the register file / pad mux
// and the pad frame.
//   dir_req_i/out_val_i/pull_en_i/pull_dn_i : per-lane requests
//   pad_oen_o/pad_i_o/pad_pen_o/pad_puen_o  : registered pad drive pins
//   pad_o_i                                 : raw pad receiver outputs
//   rx_val_o/rise_o/fall_o                  : filtered level and edge events
//   busy_o                                  : lane turnaround in progress
module pad_ctrl
    import pad_ctrl_pkg::*;
#(
    parameter int unsigned NumPads      = 8,
    parameter int unsigned DeadCycles   = 2,
    parameter int unsigned FilterCycles = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NumPads-1:0] dir_req_i,
    input  logic [NumPads-1:0] out_val_i,
    input  logic [NumPads-1:0] pull_en_i,
    input  logic [NumPads-1:0] pull_dn_i,
    output logic [NumPads-1:0] pad_oen_o,
    output logic [NumPads-1:0] pad_i_o,
    output logic [NumPads-1:0] pad_pen_o,
    output logic [NumPads-1:0] pad_puen_o,
    input  logic [NumPads-1:0] pad_o_i,
    output logic [NumPads-1:0] rx_val_o,
    output logic [NumPads-1:0] rise_o,
    output logic [NumPads-1:0] fall_o,
    output logic [NumPads-1:0] busy_o
);

    for (genvar g = 0; g < NumPads; g++) begin : g_lane
        lane_cfg_t cfg;
        lane_pad_t pad;

        assign cfg = '{
            dir_req: dir_req_i[g],
            out_val: out_val_i[g],
            pull_en: pull_en_i[g],
            pull_dn: pull_dn_i[g]
        };

        pad_ctrl_lane #(
            .DeadCycles   (DeadCycles),
            .FilterCycles (FilterCycles)
        ) u_lane (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .cfg_i     (cfg),
            .pad_ctl_o (pad),
            .pad_in_i  (pad_o_i[g]),
            .rx_val_o  (rx_val_o[g]),
            .rise_o    (rise_o[g]),
            .fall_o    (fall_o[g]),
            .busy_o    (busy_o[g])
        );

        assign pad_oen_o[g]  = pad.oen;
        assign pad_i_o[g]    = pad.i;
        assign pad_pen_o[g]  = pad.pen;
        assign pad_puen_o[g] = pad.puen;
    end

endmodule

// File: tb/tb_pad_ctrl.sv
// Self-checking bench for pad_ctrl: directed vectors for turnaround, filter
// and reset corner cases, then randomized traffic against a behavioural model.
module tb_pad_ctrl;

    localparam int NP = 8;
    localparam int DC = 2;
    localparam int FC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NP-1:0] dir_req, out_val, pull_en, pull_dn, pad_o;
    logic [NP-1:0] pad_oen, pad_i, pad_pen, pad_puen, rx_val, rise, fall, busy;

    always #5 clk = ~clk;

    pad_ctrl #(
        .NumPads      (NP),
        .DeadCycles   (DC),
        .FilterCycles (FC)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .dir_req_i  (dir_req),
        .out_val_i  (out_val),
        .pull_en_i  (pull_en),
        .pull_dn_i  (pull_dn),
        .pad_oen_o  (pad_oen),
        .pad_i_o    (pad_i),
        .pad_pen_o  (pad_pen),
        .pad_puen_o (pad_puen),
        .pad_o_i    (pad_o),
        .rx_val_o   (rx_val),
        .rise_o     (rise),
        .fall_o     (fall),
        .busy_o     (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [NP-1:0] act, input logic [NP-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Driver and pull must never be on together.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_tests++;
            if ((~pad_oen & ~pad_pen) !== '0) begin
                n_fail++;
                $display("FAIL overlap @%0t: oen %b pen %b", $time, pad_oen, pad_pen);
            end
        end
    end

    // ---------------- behavioural model ----------------
    localparam int MIn = 0, MTurnOut = 1, MOut = 2, MTurnIn = 3;
    int            m_mode[NP];
    int            m_done[NP];
    int            cyc;
    logic [NP-1:0] m_oen, m_i, m_pen, m_puen, m_rx, m_rise, m_fall, m_busy;
    logic [NP-1:0] m_hist[$];  // last FC pad samples, oldest first

    task automatic model_reset();
        for (int l = 0; l < NP; l++) begin
            m_mode[l] = MIn;
            m_done[l] = 0;
        end
        m_oen = '1; m_i = '0; m_pen = '0; m_puen = '0;
        m_rx = '1; m_rise = '0; m_fall = '0; m_busy = '0;
        m_hist.delete();
        for (int j = 0; j < FC; j++) m_hist.push_back('1);
        cyc = 0;
    endtask

    task automatic model_step();
        cyc++;
        for (int l = 0; l < NP; l++) begin
            bit all_diff = 1'b1;
            foreach (m_hist[j]) if (m_hist[j][l] == m_rx[l]) all_diff = 1'b0;
            m_rise[l] = all_diff && (m_mode[l] == MIn) && !m_rx[l];
            m_fall[l] = all_diff && (m_mode[l] == MIn) && m_rx[l];
            if (all_diff) m_rx[l] = ~m_rx[l];
            case (m_mode[l])
                MIn: begin
                    if (dir_req[l]) begin
                        m_mode[l] = MTurnOut; m_done[l] = cyc + DC;
                        m_busy[l] = 1'b1; m_pen[l] = 1'b1; m_i[l] = out_val[l];
                    end else begin
                        m_busy[l] = 1'b0; m_pen[l] = ~pull_en[l]; m_puen[l] = pull_dn[l];
                    end
                end
                MTurnOut: begin
                    m_i[l] = out_val[l];
                    if (cyc == m_done[l]) begin
                        m_mode[l] = MOut; m_oen[l] = 1'b0; m_busy[l] = 1'b0;
                    end
                end
                MOut: begin
                    m_i[l] = out_val[l];
                    if (!dir_req[l]) begin
                        m_mode[l] = MTurnIn; m_done[l] = cyc + DC;
                        m_oen[l] = 1'b1; m_busy[l] = 1'b1;
                    end
                end
                default: begin
                    if (cyc == m_done[l]) begin
                        m_mode[l] = MIn; m_busy[l] = 1'b0;
                        m_pen[l] = ~pull_en[l]; m_puen[l] = pull_dn[l];
                    end
                end
            endcase
        end
        m_hist.push_back(pad_o);
        void'(m_hist.pop_front());
    endtask

    // One clock edge, model in lock-step; returns at the following negedge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic check_model();
        check("rnd_oen", pad_oen, m_oen);
        check("rnd_i", pad_i, m_i);
        check("rnd_pen", pad_pen, m_pen);
        check("rnd_puen", pad_puen, m_puen);
        check("rnd_rx", rx_val, m_rx);
        check("rnd_rise", rise, m_rise);
        check("rnd_fall", fall, m_fall);
        check("rnd_busy", busy, m_busy);
    endtask

    typedef struct packed {
        logic dir, outv, pull, dn;
        logic e_oen, e_i, e_pen, e_puen, e_busy;
    } vec_t;

    vec_t     tbl[8];
    bit [6:0] p_oen  = 7'b1111_011;  // pulse test, index = edge-1, LSB first
    bit [6:0] p_busy = 7'b0011_011;
    bit [6:0] p_pen  = 7'b0011_111;

    initial begin
        // lane-0 turnaround: inputs before the edge, expected pins after it
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        dir_req = '0; out_val = '0; pull_en = '1; pull_dn = '0; pad_o = '1;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_oen", pad_oen, '1);
        check("rst_pen", pad_pen, '0);
        check("rst_puen", pad_puen, '0);
        check("rst_i", pad_i, '0);
        check("rst_rx", rx_val, '1);
        check("rst_busy", busy, '0);
        rst_n = 1'b1;

        // quiet period after reset release
        for (int c = 0; c < 20; c++) begin
            cycle();
            check("quiet_rise", rise, '0);
            check("quiet_fall", fall, '0);
        end
        check("quiet_oen", pad_oen, '1);
        check("quiet_pen", pad_pen, '0);
        check("quiet_rx", rx_val, '1);

        // table-driven lane-0 round trip
        for (int r = 0; r < 8; r++) begin
            dir_req[0] = tbl[r].dir;
            out_val[0] = tbl[r].outv;
            pull_en[0] = tbl[r].pull;
            pull_dn[0] = tbl[r].dn;
            cycle();
            check($sformatf("tbl%0d_oen", r), pad_oen, {7'h7F, tbl[r].e_oen});
            check($sformatf("tbl%0d_i", r), pad_i, {7'h00, tbl[r].e_i});
            check($sformatf("tbl%0d_pen", r), pad_pen, {7'h00, tbl[r].e_pen});
            check($sformatf("tbl%0d_puen", r), pad_puen, {7'h00, tbl[r].e_puen});
            check($sformatf("tbl%0d_busy", r), busy, {7'h00, tbl[r].e_busy});
        end
        pull_en[0] = 1'b1;
        cycle();

        // lane 3: 3-cycle glitch is rejected
        pad_o[3] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            if (e == 4) pad_o[3] = 1'b1;
            cycle();
            check("glitch_rx", rx_val, '1);
            check("glitch_fall", fall, '0);
        end
        // lane 3: held change lands on the 5th edge with one event
        for (int pol = 0; pol < 2; pol++) begin
            logic lvl;
            lvl = (pol == 1);
            pad_o[3] = lvl;
            for (int e = 1; e <= 6; e++) begin
                logic          exp_lvl;
                logic [NP-1:0] exp_rx;
                cycle();
                exp_lvl   = (e >= 5) ? lvl : ~lvl;
                exp_rx    = '1;
                exp_rx[3] = exp_lvl;
                check("filt_rx", rx_val, exp_rx);
                check("filt_rise", rise, (e == 5 && lvl) ? 8'h08 : 8'h00);
                check("filt_fall", fall, (e == 5 && !lvl) ? 8'h08 : 8'h00);
            end
        end

        // lane 2: one-cycle direction pulse gives exactly one round trip
        dir_req[2] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            logic [NP-1:0] exp_oen, exp_busy, exp_pen;
            cycle();
            dir_req[2]  = 1'b0;
            exp_oen     = '1;
            exp_oen[2]  = p_oen[e-1];
            exp_busy    = '0;
            exp_busy[2] = p_busy[e-1];
            exp_pen     = '0;
            exp_pen[2]  = p_pen[e-1];
            check($sformatf("pulse%0d_oen", e), pad_oen, exp_oen);
            check($sformatf("pulse%0d_busy", e), busy, exp_busy);
            check($sformatf("pulse%0d_pen", e), pad_pen, exp_pen);
        end

        // asynchronous reset in the middle of TURN_OUT
        dir_req[0] = 1'b1;
        out_val[0] = 1'b1;
        cycle();
        check("pre_rst_busy", busy, 8'h01);
        #2;
        rst_n = 1'b0;
        dir_req = '0;
        out_val = '0;
        model_reset();
        #1;
        check("arst_oen", pad_oen, '1);
        check("arst_pen", pad_pen, '0);
        check("arst_busy", busy, '0);
        check("arst_i", pad_i, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            dir_req ^= NP'($urandom & $urandom & $urandom);
            pull_en ^= NP'($urandom & $urandom & $urandom & $urandom);
            pull_dn ^= NP'($urandom & $urandom & $urandom & $urandom);
            pad_o   ^= NP'($urandom & $urandom & $urandom);
            out_val  = NP'($urandom);
            cycle();
            check_model();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
